regbank_multiport: RTL and testbench



---
 rtl/regbank_pkg.sv | 13 +
 rtl/regbank_rdport.sv | 52 +++++
 rtl/regbank_multiport.sv | 103 ++++++++++
 tb/tb_regbank_multiport.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared state encoding and default sizes for the multiport register bank
package regbank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regbank_rdport.sv
// rtl/regbank_rdport.sv - one registered read port: zero-register mask, optional write bypass (REGBANK_BYPASS_EN)
module regbank_rdport
    import regbank_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] mem_val,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] data_next;

`ifdef REGBANK_BYPASS_EN
    always_comb begin
        data_next = mem_val;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data_next = '0;
        end else if (wr_en && (addr == wr_addr)) begin
            data_next = wr_data;
        end
    end
`else
    // Without bypass the port returns the pre-write contents, so the write side is unused here.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        data_next = mem_val;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data_next = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data <= '0;
        end else begin
            data <= data_next;
        end
    end

endmodule

// File: rtl/regbank_multiport.sv
// rtl/regbank_multiport.sv - multi-read-port register bank with post-reset clear sequence; REGBANK_BYPASS_EN enables write-to-read bypass
module regbank_multiport
    import regbank_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                regwrite,
    input  logic                memtoreg,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic                busy
);

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] wr_data;
    logic            wr_accept;

    assign wr_data   = memtoreg ? mem_rdata : alu_result;
    assign wr_accept = regwrite && !busy && !rst
                       && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst && busy) begin
            mem[clr_idx] <= '0;
        end else if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regbank_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clk      (clk),
            .rst      (rst),
            .clear    (busy),
            .addr     (rd_addr[i*AW +: AW]),
            .mem_val  (mem[rd_addr[i*AW +: AW]]),
            .wr_en    (wr_accept),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[i*XLEN +: XLEN])
        );
    end

    regbank_rdport #(
        .XLEN     (XLEN),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_dbgport (
        .clk      (clk),
        .rst      (rst),
        .clear    (busy),
        .addr     (dbg_addr),
        .mem_val  (mem[dbg_addr]),
        .wr_en    (wr_accept),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .data     (dbg_data)
    );

endmodule

// File: tb/tb_regbank_multiport.sv
// tb/tb_regbank_multiport.sv - directed self-checking bench for regbank_multiport
module tb_regbank_multiport;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                regwrite;
    logic                memtoreg;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     mem_rdata;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

`ifdef REGBANK_BYPASS_EN
    localparam logic [31:0] COLLIDE_EXP = 32'd2;
`else
    localparam logic [31:0] COLLIDE_EXP = 32'd1;
`endif

    regbank_multiport dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .regwrite   (regwrite),
        .memtoreg   (memtoreg),
        .wr_addr    (wr_addr),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic write_reg(input logic [AW-1:0] a, input logic sel,
                             input logic [31:0] alu, input logic [31:0] mem);
        regwrite   = 1'b1;
        wr_addr    = a;
        memtoreg   = sel;
        alu_result = alu;
        mem_rdata  = mem;
        @(negedge clk);
        regwrite   = 1'b0;
    endtask

    task automatic read_regs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] ad);
        rd_addr  = {a1, a0};
        dbg_addr = ad;
        @(negedge clk);
    endtask

    task automatic count_busy(input int drop_at, input logic [AW-1:0] probe);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == drop_at) regwrite = 1'b0;
            if (cnt == 3) check("rd_zero_in_clear", rd_data[31:0], 32'h0);
            rd_addr[AW-1:0] = probe;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_addr = '0; regwrite = 1'b0; memtoreg = 1'b0;
        wr_addr = '0; alu_result = '0; mem_rdata = '0; dbg_addr = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_rd0", rd_data[31:0], 32'h0);
        check("reset_rd1", rd_data[63:32], 32'h0);
        check("reset_dbg", dbg_data, 32'h0);

        rst = 1'b0;
        count_busy(0, 5'd0);
        check("busy_cycles", cnt, 32'd32);

        for (int r = 0; r < 32; r++) begin
            read_regs(r[AW-1:0], r[AW-1:0], r[AW-1:0]);
            check($sformatf("clr_rd0_x%0d", r), rd_data[31:0], 32'h0);
            check($sformatf("clr_dbg_x%0d", r), dbg_data, 32'h0);
        end

        write_reg(5'd5, 1'b0, 32'h0000_00A5, 32'h1111_1111);
        read_regs(5'd5, 5'd0, 5'd0);
        check("alu_write_x5", rd_data[31:0], 32'h0000_00A5);

        write_reg(5'd31, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
        read_regs(5'd5, 5'd31, 5'd31);
        check("mem_write_p1", rd_data[63:32], 32'hDEAD_BEEF);
        check("mem_write_dbg", dbg_data, 32'hDEAD_BEEF);
        check("x5_kept", rd_data[31:0], 32'h0000_00A5);

        rd_addr = '0; dbg_addr = '0;
        write_reg(5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("x0_bypass_rd0", rd_data[31:0], 32'h0);
        read_regs(5'd0, 5'd0, 5'd0);
        check("x0_rd0", rd_data[31:0], 32'h0);
        check("x0_rd1", rd_data[63:32], 32'h0);
        check("x0_dbg", dbg_data, 32'h0);

        write_reg(5'd7, 1'b0, 32'd1, 32'd0);
        rd_addr = {5'd31, 5'd7}; dbg_addr = 5'd7;
        write_reg(5'd7, 1'b0, 32'd2, 32'd0);
        check("collide_rd0", rd_data[31:0], COLLIDE_EXP);
        check("collide_dbg", dbg_data, COLLIDE_EXP);
        check("collide_other", rd_data[63:32], 32'hDEAD_BEEF);
        read_regs(5'd7, 5'd7, 5'd7);
        check("after_collide", rd_data[31:0], 32'd2);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        regwrite = 1'b1; wr_addr = 5'd2; memtoreg = 1'b0; alu_result = 32'h0000_0055;
        count_busy(6, 5'd5);
        check("mid_busy_cycles", cnt, 32'd32);
        read_regs(5'd2, 5'd5, 5'd31);
        check("dropped_write_x2", rd_data[31:0], 32'h0);
        check("recleared_x5", rd_data[63:32], 32'h0);
        check("recleared_x31", dbg_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
